// File: rtl/sync_debounce_if.sv
// Board-input conditioner bus: raw inputs and sample strobe in,
// debounced levels and registered edge pulses out.
interface sync_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i_in;
  logic             i_sample_en;
  logic [WIDTH-1:0] o_out;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_any_edge;

  modport slave (
    input  i_in, i_sample_en,
    output o_out, o_rise, o_fall, o_any_edge
  );

  modport master (
    output i_in, i_sample_en,
    input  o_out, o_rise, o_fall, o_any_edge
  );
endinterface

// File: rtl/sync_debounce.sv
// Multi-channel synchroniser + debounce filter with registered rise/fall
// pulses; one lane instance per channel, lanes fully independent.
module sync_debounce_lane #(
  parameter int STAGES    = 2,
  parameter int DEBOUNCE  = 4,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  input  logic i_sample_en,
  output logic o_out,
  output logic o_rise,
  output logic o_fall
);
  localparam int            CW   = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_out;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;

  assign w_s = r_sync[STAGES-1];

  // Sync chain runs every cycle; the strobe only gates the debounce count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {STAGES{RESET_VAL}};
    else     r_sync <= {r_sync[STAGES-2:0], i_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_out  <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_s == r_out) begin
        r_cnt <= '0;
      end else if (i_sample_en) begin
        if (r_cnt == LAST) begin
          r_out  <= w_s;
          r_cnt  <= '0;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
endmodule

module sync_debounce #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int DEBOUNCE  = 4,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  sync_debounce_if.slave  bus
);
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    sync_debounce_lane #(
      .STAGES    (STAGES),
      .DEBOUNCE  (DEBOUNCE),
      .RESET_VAL (RESET_VAL)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .i_in        (bus.i_in[g]),
      .i_sample_en (bus.i_sample_en),
      .o_out       (w_out[g]),
      .o_rise      (w_rise[g]),
      .o_fall      (w_fall[g])
    );
  end

  assign bus.o_out      = w_out;
  assign bus.o_rise     = w_rise;
  assign bus.o_fall     = w_fall;
  // Built only from registered pulses, so no path from raw inputs.
  assign bus.o_any_edge = |(w_rise | w_fall);
endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: expectations queued with stimulus,
// popped and checked one cycle later; second instance covers RESET_VAL=1.
module tb_sync_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_debounce_if #(.WIDTH(4)) bus ();
  sync_debounce_if #(.WIDTH(4)) bus2 ();

  sync_debounce #(.WIDTH(4), .STAGES(2), .DEBOUNCE(3), .RESET_VAL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sync_debounce #(.WIDTH(4), .STAGES(2), .DEBOUNCE(3), .RESET_VAL(1'b1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    string      tag;
    logic [3:0] o;
    logic [3:0] r;
    logic [3:0] f;
    logic       a;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input string tag, input logic [3:0] eo, input logic [3:0] er,
                      input logic [3:0] ef);
    exp_t e;
    e.tag = tag; e.o = eo; e.r = er; e.f = ef; e.a = |(er | ef);
    q.push_back(e);
  endtask

  task automatic chk();
    exp_t e;
    if (q.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL scoreboard empty act=%0d exp=1", q.size());
      return;
    end
    e = q.pop_front();
    n_tests++;
    assert (bus.o_out === e.o) else begin
      n_fail++; $error("FAIL %s out act=%b exp=%b", e.tag, bus.o_out, e.o);
    end
    n_tests++;
    assert (bus.o_rise === e.r) else begin
      n_fail++; $error("FAIL %s rise act=%b exp=%b", e.tag, bus.o_rise, e.r);
    end
    n_tests++;
    assert (bus.o_fall === e.f) else begin
      n_fail++; $error("FAIL %s fall act=%b exp=%b", e.tag, bus.o_fall, e.f);
    end
    n_tests++;
    assert (bus.o_any_edge === e.a) else begin
      n_fail++; $error("FAIL %s any_edge act=%b exp=%b", e.tag, bus.o_any_edge, e.a);
    end
  endtask

  // Queue expectation for the coming edge, take the edge, check #1 after.
  task automatic cyc(input string tag, input logic [3:0] eo, input logic [3:0] er,
                     input logic [3:0] ef);
    push(tag, eo, er, ef);
    @(posedge clk); #1;
    chk();
  endtask

  task automatic now_chk(input string tag, input logic [3:0] eo);
    push(tag, eo, 4'b0000, 4'b0000);
    chk();
  endtask

  task automatic chk2(input string tag);
    n_tests++;
    assert (bus2.o_out === 4'b1111) else begin
      n_fail++; $error("FAIL %s rv1 out act=%b exp=%b", tag, bus2.o_out, 4'b1111);
    end
    n_tests++;
    assert ((bus2.o_rise | bus2.o_fall) === 4'b0000 && bus2.o_any_edge === 1'b0) else begin
      n_fail++; $error("FAIL %s rv1 pulses act=%b%b exp=00000000", tag, bus2.o_rise,
                       bus2.o_fall);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bus.i_in = 4'b0000; bus.i_sample_en = 1'b1;
    bus2.i_in = 4'b1111; bus2.i_sample_en = 1'b1;

    // 1: reset state, nothing on release
    repeat (2) @(posedge clk);
    #1;
    now_chk("t1_in_reset", 4'b0000);
    chk2("t1_in_reset");
    rst = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      cyc("t1_post_release", 4'b0000, 4'b0000, 4'b0000);
      chk2("t1_post_release");
    end

    // 2: ch0 rise, latency STAGES+DEBOUNCE = 5
    bus.i_in = 4'b0001;
    for (int n = 1; n <= 7; n++)
      cyc("t2_rise", (n >= 5) ? 4'b0001 : 4'b0000, (n == 5) ? 4'b0001 : 4'b0000, 4'b0000);

    // 3: 2-cycle glitch on ch1 is rejected
    bus.i_in = 4'b0011;
    cyc("t3_glitch", 4'b0001, 4'b0000, 4'b0000);
    cyc("t3_glitch", 4'b0001, 4'b0000, 4'b0000);
    bus.i_in = 4'b0001;
    for (int n = 3; n <= 9; n++)
      cyc("t3_glitch", 4'b0001, 4'b0000, 4'b0000);

    // 4: ch2 up, then down with a strobe every 4th edge
    bus.i_in = 4'b0101;
    for (int n = 1; n <= 6; n++)
      cyc("t4_up", (n >= 5) ? 4'b0101 : 4'b0001, (n == 5) ? 4'b0100 : 4'b0000, 4'b0000);
    bus.i_in = 4'b0001;
    for (int n = 1; n <= 14; n++) begin
      bus.i_sample_en = (n % 4 == 0);
      cyc("t4_strobe", (n >= 12) ? 4'b0001 : 4'b0101, 4'b0000,
          (n == 12) ? 4'b0100 : 4'b0000);
    end
    bus.i_sample_en = 1'b1;

    // 5: reset mid-count clears asynchronously, full latency again after
    bus.i_in = 4'b0011;
    for (int n = 1; n <= 3; n++)
      cyc("t5_count", 4'b0001, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    now_chk("t5_async_clear", 4'b0000);
    cyc("t5_in_reset", 4'b0000, 4'b0000, 4'b0000);
    cyc("t5_in_reset", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int n = 1; n <= 7; n++)
      cyc("t5_after_release", (n >= 5) ? 4'b0011 : 4'b0000,
          (n == 5) ? 4'b0011 : 4'b0000, 4'b0000);

    // 6: all channels at once, up then down; RESET_VAL=1 instance stays quiet
    bus.i_in = 4'b0000;
    pulse_reset();
    bus.i_in = 4'b1111;
    for (int n = 1; n <= 7; n++) begin
      cyc("t6_all_rise", (n >= 5) ? 4'b1111 : 4'b0000, (n == 5) ? 4'b1111 : 4'b0000, 4'b0000);
      chk2("t6_rv1");
    end
    bus.i_in = 4'b0000;
    for (int n = 1; n <= 7; n++)
      cyc("t6_all_fall", (n >= 5) ? 4'b0000 : 4'b1111, 4'b0000, (n == 5) ? 4'b1111 : 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
